// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// regfile_pkg : shared widths, arbitration pointer encoding and writeback type
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic [0:0] {
      PRI_ALU = 1'b0,
      PRI_LSU = 1'b1
   } pri_e;

   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
   } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// rr_arb2  : two-requester round-robin arbiter, req/gnt bit 0 = ALU, bit 1 = LSU
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   pri_e ptr;
   pri_e ptr_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= PRI_LSU;
      end else begin
         ptr <= ptr_next;
      end
   end

   // The pointer only advances when both requesters compete; the loser gets priority next.
   always_comb begin
      gnt      = 2'b00;
      ptr_next = ptr;
      if (rst_n) begin
         case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
               if (ptr == PRI_ALU) begin
                  gnt      = 2'b01;
                  ptr_next = PRI_LSU;
               end else begin
                  gnt      = 2'b10;
                  ptr_next = PRI_ALU;
               end
            end
            default: gnt = 2'b00;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_sched.sv
//------------------------------------------------------------------------------
// regfile_wb_sched : ALU/LSU writeback arbitration, registered RF write port
//                    and pending-write scoreboard with decode hazard detection
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wb_sched
   import regfile_pkg::*;
#(
   parameter int XLEN = regfile_pkg::XLEN,
   parameter int AW   = regfile_pkg::AW
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alu_valid,
   output logic                alu_ready,
   input  logic [AW-1:0]       alu_rd,
   input  logic [XLEN-1:0]     alu_data,
   input  logic                lsu_valid,
   output logic                lsu_ready,
   input  logic [AW-1:0]       lsu_rd,
   input  logic [XLEN-1:0]     lsu_data,
   input  logic                issue_valid,
   input  logic [AW-1:0]       issue_rd,
   input  logic [AW-1:0]       rs1,
   input  logic [AW-1:0]       rs2,
   output logic                hazard,
   output logic                rf_we,
   output logic [AW-1:0]       rf_waddr,
   output logic [XLEN-1:0]     rf_wdata,
   input  logic                flush,
   output logic [NUM_REGS-1:0] busy_mask
);

   wb_req_t             alu_req;
   wb_req_t             lsu_req;
   wb_req_t             win_req;
   logic [1:0]          gnt;
   logic                accept;
   logic                do_write;
   logic [NUM_REGS-1:0] busy_next;

   assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
   assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({lsu_req.valid, alu_req.valid}),
      .gnt   (gnt)
   );

   assign alu_ready = gnt[0];
   assign lsu_ready = gnt[1];
   assign win_req   = gnt[1] ? lsu_req : alu_req;
   assign accept    = |gnt;
   // Writes to x0 are handshaken normally but never reach the register file.
   assign do_write  = accept && (win_req.rd != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= do_write;
         if (do_write) begin
            rf_waddr <= win_req.rd;
            rf_wdata <= win_req.data;
         end
      end
   end

   // Set is applied after clear so a same-register issue wins over a retiring write.
   always_comb begin
      busy_next = busy_mask;
      if (flush) begin
         busy_next = '0;
      end else begin
         if (rf_we) begin
            busy_next[rf_waddr] = 1'b0;
         end
         if (issue_valid && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
         end
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_mask <= '0;
      end else begin
         busy_mask <= busy_next;
      end
   end

   assign hazard = (busy_mask[rs1] && (rs1 != '0)) || (busy_mask[rs2] && (rs2 != '0));

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
//------------------------------------------------------------------------------
// tb_regfile_wb_sched : directed stimulus, behavioural reference model checked
//                       on every falling edge plus hand-computed expectations
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid, lsu_valid, issue_valid, flush;
   logic [4:0]  alu_rd, lsu_rd, issue_rd, rs1, rs2;
   logic [31:0] alu_data, lsu_data;
   logic        alu_ready, lsu_ready, hazard, rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy_mask;

   int n_vec = 0;
   int n_err = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   regfile_wb_sched #(.XLEN(32), .AW(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_ready   (alu_ready),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rs1         (rs1),
      .rs2         (rs2),
      .hazard      (hazard),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .flush       (flush),
      .busy_mask   (busy_mask)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: m_lsu_first says who wins the next contest.
   bit        m_lsu_first;
   bit        m_we;
   bit [4:0]  m_waddr;
   bit [31:0] m_wdata;
   bit [31:0] m_busy;

   always @(posedge clk or negedge rst_n) begin
      bit ag, lg;
      if (!rst_n) begin
         m_lsu_first = 1'b1;
         m_we        = 1'b0;
         m_waddr     = '0;
         m_wdata     = '0;
         m_busy      = '0;
      end else begin
         ag = alu_valid && (!lsu_valid || !m_lsu_first);
         lg = lsu_valid && (!alu_valid || m_lsu_first);
         if (flush) m_busy = '0;
         else begin
            if (m_we) m_busy[m_waddr] = 1'b0;
            if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
         end
         if (alu_valid && lsu_valid) m_lsu_first = !m_lsu_first;
         if (ag && alu_rd != 0) begin
            m_we = 1'b1; m_waddr = alu_rd; m_wdata = alu_data;
         end else if (lg && lsu_rd != 0) begin
            m_we = 1'b1; m_waddr = lsu_rd; m_wdata = lsu_data;
         end else begin
            m_we = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("alu_ready", alu_ready, rst_n && alu_valid && (!lsu_valid || !m_lsu_first));
         check("lsu_ready", lsu_ready, rst_n && lsu_valid && (!alu_valid || m_lsu_first));
         check("hazard", hazard, (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2]));
         check("rf_we", rf_we, m_we);
         check("busy_mask", busy_mask, m_busy);
         if (m_we || !rst_n) begin
            check("rf_waddr", rf_waddr, m_waddr);
            check("rf_wdata", rf_wdata, m_wdata);
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   typedef struct packed {
      bit av; bit [4:0] ar; bit lv; bit [4:0] lr; bit iv; bit [4:0] ir; bit fl;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      {alu_valid, lsu_valid, issue_valid, flush} = '0;
      {alu_rd, lsu_rd, issue_rd, rs1, rs2} = '0;
      alu_data = '0; lsu_data = '0;
      #1 rst_n = 1'b0;
      #1 started = 1'b1;

      // Requests presented during reset must be ignored.
      alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h0000_0011;
      lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h0000_0022;
      tick; tick;
      #1;
      check("reset_alu_ready", alu_ready, 1'b0);
      check("reset_lsu_ready", lsu_ready, 1'b0);
      check("reset_rf_we", rf_we, 1'b0);
      check("reset_busy", busy_mask, 32'h0);
      tick;
      rst_n = 1'b1;

      // Contested grants alternate starting with LSU.
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr_lsu_ready", lsu_ready, (i % 2 == 0));
         check("rr_alu_ready", alu_ready, (i % 2 == 1));
         tick;
         if (i == 3) begin alu_valid = 0; lsu_valid = 0; end
         #1;
         check("rr_rf_we", rf_we, 1'b1);
         check("rr_rf_waddr", rf_waddr, (i % 2 == 0) ? 5'd2 : 5'd1);
      end
      tick;

      // Single ALU writeback.
      alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
      #1 check("single_alu_ready", alu_ready, 1'b1);
      tick;
      alu_valid = 0;
      #1;
      check("single_rf_we", rf_we, 1'b1);
      check("single_rf_waddr", rf_waddr, 5'd5);
      check("single_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
      tick;
      #1 check("single_rf_we_drop", rf_we, 1'b0);

      // Uncontested grant leaves LSU with priority.
      alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h33;
      lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h44;
      #1 check("uncontested_keeps_ptr", lsu_ready, 1'b1);
      tick;
      alu_valid = 0; lsu_valid = 0;
      tick;

      // Hazard on a pending destination until its write retires.
      issue_valid = 1; issue_rd = 5'd7;
      tick;
      issue_valid = 0; rs1 = 5'd7;
      #1 check("hazard_set", hazard, 1'b1);
      tick;
      alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
      tick;
      alu_valid = 0;
      #1;
      check("hazard_during_we", hazard, 1'b1);
      check("hazard_we_addr", rf_waddr, 5'd7);
      tick;
      #1 check("hazard_cleared", hazard, 1'b0);
      rs1 = 5'd0;

      // Set beats clear on the same register.
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h99;
      tick;
      alu_valid = 0; issue_valid = 1; issue_rd = 5'd9;
      tick;
      issue_valid = 0;
      #1 check("set_priority_bit9", busy_mask[9], 1'b1);

      // x0 writeback: handshaken, never written, never marked busy.
      lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h55;
      issue_valid = 1; issue_rd = 5'd0;
      #1 check("x0_lsu_ready", lsu_ready, 1'b1);
      tick;
      lsu_valid = 0; issue_valid = 0;
      #1;
      check("x0_rf_we", rf_we, 1'b0);
      check("x0_busy0", busy_mask[0], 1'b0);

      // Flush clears the scoreboard and ignores a same-cycle issue.
      flush = 1;
      tick;
      flush = 0;
      for (int r = 4; r < 8; r++) begin
         issue_valid = 1; issue_rd = 5'(r);
         tick;
      end
      issue_valid = 0;
      #1 check("busy_f0", busy_mask, 32'h0000_00F0);
      flush = 1; issue_valid = 1; issue_rd = 5'd3;
      tick;
      flush = 0; issue_valid = 0;
      #1 check("flush_clears", busy_mask, 32'h0);

      // Mixed directed vectors checked against the model only.
      vecs[0] = '{1'b1, 5'd3,  1'b1, 5'd4,  1'b1, 5'd12, 1'b0};
      vecs[1] = '{1'b1, 5'd12, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0};
      vecs[2] = '{1'b0, 5'd0,  1'b1, 5'd13, 1'b1, 5'd13, 1'b0};
      vecs[3] = '{1'b1, 5'd14, 1'b1, 5'd15, 1'b1, 5'd15, 1'b0};
      vecs[4] = '{1'b1, 5'd15, 1'b1, 5'd14, 1'b1, 5'd14, 1'b1};
      vecs[5] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b1, 5'd20, 1'b0};
      vecs[6] = '{1'b1, 5'd0,  1'b1, 5'd16, 1'b1, 5'd17, 1'b0};
      vecs[7] = '{1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 5'd0,  1'b0};
      for (int i = 0; i < 8; i++) begin
         alu_valid = vecs[i].av; alu_rd = vecs[i].ar; alu_data = 32'hA000_0000 + 32'(i);
         lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lr; lsu_data = 32'hB000_0000 + 32'(i);
         issue_valid = vecs[i].iv; issue_rd = vecs[i].ir; flush = vecs[i].fl;
         rs1 = vecs[i].ir; rs2 = 5'd14;
         tick;
      end
      {alu_valid, lsu_valid, issue_valid, flush} = '0;
      tick;

      // Reset in the middle of a transfer cancels the pending write at once.
      alu_valid = 1; alu_rd = 5'd12; alu_data = 32'hC;
      tick;
      alu_valid = 0;
      #1 check("pre_reset_rf_we", rf_we, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midreset_rf_we", rf_we, 1'b0);
      check("midreset_rf_waddr", rf_waddr, 5'd0);
      tick;
      rst_n = 1'b1;
      tick; tick;

      started = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the register file write port.
REQ-002 SHALL have parameter AW, default 5, register address width (32 architectural registers).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports alu_valid/alu_ready  input/output  1/1  ALU writeback handshake.
REQ-006 SHALL have ports alu_rd/alu_data  input  AW/XLEN  ALU destination register and result.
REQ-007 SHALL have ports lsu_valid/lsu_ready  input/output  1/1  load-unit writeback handshake.
REQ-008 SHALL have ports lsu_rd/lsu_data  input  AW/XLEN  load destination register and data.
REQ-009 SHALL have ports issue_valid/issue_rd  input  1/AW  instruction issued that will write issue_rd.
REQ-010 SHALL have ports rs1/rs2  input  AW/AW  source registers of the instruction in decode.
REQ-011 SHALL have port hazard  output  1  decode must stall: a source register has a pending write.
REQ-012 SHALL have ports rf_we/rf_waddr/rf_wdata  output  1/AW/XLEN  registered drive of the register file write port.
REQ-013 SHALL have ports flush/busy_mask  input/output  1/32  pipeline flush; scoreboard pending-write bits.

Function
REQ-014 SHALL accept a requester when its valid and ready are both high on a rising edge; ready is combinational from arbiter state and valids.
REQ-015 SHALL grant at most one requester per cycle; with one valid, that requester gets ready=1.
REQ-016 SHALL arbitrate simultaneous valids round-robin: 2-state pointer PRI_ALU/PRI_LSU, winner is the pointed requester, pointer moves to the loser after each contested grant only.
REQ-017 SHALL leave the pointer unchanged on uncontested grants and idle cycles.
REQ-018 SHALL register an accepted write: rf_we=1, rf_waddr, rf_wdata exactly one cycle after acceptance (latency 1), rf_we=0 otherwise.
REQ-019 SHALL accept writes to register 0 (ready asserted) but keep rf_we=0 for them.
REQ-020 SHALL set busy_mask[issue_rd] on the edge where issue_valid=1 and issue_rd!=0.
REQ-021 SHALL clear busy_mask[rf_waddr] on the edge where rf_we=1.
REQ-022 SHALL give set priority when set and clear target the same register on the same edge.
REQ-023 SHALL hold busy_mask[0]=0 always.
REQ-024 SHALL drive hazard = (busy_mask[rs1] & rs1!=0) | (busy_mask[rs2] & rs2!=0), combinational, no bypass.
REQ-025 SHALL on flush=1 clear all busy_mask bits on that edge, ignore issue_valid that cycle, still complete any write already registered on rf_we, and keep accepting writebacks.
REQ-026 SHALL not lose or duplicate a write: each accepted request produces exactly one rf_we pulse (unless rd=0).

Reset
REQ-027 SHALL, while rst_n=0, force rf_we=0, rf_waddr=0, rf_wdata=0, busy_mask=0, pointer=PRI_LSU, alu_ready=lsu_ready=0.
REQ-028 SHALL discard any request presented during reset; a reset asserted mid-transfer cancels the pending rf_we pulse.
REQ-029 SHALL resume normal arbitration on the first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL take XLEN, AW, NUM_REGS=32 and typedef wb_req_t (valid, rd, data) from shared package regfile_pkg.
REQ-031 SHALL implement arbitration in one sub-module rr_arb2 (2 requests, 2 grants, pointer state).
REQ-032 SHALL keep scoreboard and write-port registers in regfile_wb_sched top.

Verification
REQ-033 SHALL cover: only alu_valid, alu_rd=5, alu_data=0xDEADBEEF -> alu_ready=1, next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-034 SHALL cover: both valid for 4 cycles after reset (ALU rd=1, LSU rd=2) -> grants LSU,ALU,LSU,ALU; rf_waddr 2,1,2,1.
REQ-035 SHALL cover: issue_rd=7, then rs1=7 -> hazard=1 until cycle after ALU write to 7 shows rf_we=1, then hazard=0.
REQ-036 SHALL cover: rf_we to reg 9 and issue_rd=9 same edge -> busy_mask[9]=1 afterwards.
REQ-037 SHALL cover: lsu_rd=0 accepted -> lsu_ready=1, rf_we stays 0, busy_mask[0]=0.
REQ-038 SHALL cover: busy_mask=0x0000_00F0 then flush=1 -> busy_mask=0 next cycle; rst_n low mid-transfer -> rf_we=0 immediately.
